stream_demux: RTL and testbench
===============================

Name: stream_demux

Overview:
- Packet-level stream demultiplexer; the fan-out counterpart of the QoS stream arbiter.
- Takes one valid/ready input stream tagged with a destination id and routes each packet to one of STREAM_COUNT output streams.
- The route is locked from the first beat to s_last_i; per-output single-entry register slice gives 1-cycle latency at full throughput.
- Packets with an out-of-range id are consumed, discarded and counted.

Parameters:
- STREAM_COUNT, 2, number of output streams (>=2)
- T_DATA_WIDTH, 8, payload width per beat
- T_QOS_WIDTH, 4, QoS tag width, forwarded unchanged
- T_ID_WIDTH, 1, destination id width; must be >= $clog2(STREAM_COUNT)

Ports:
- clk  input  1  clock, all logic on rising edge
- nrst  input  1  asynchronous active-low reset
- s_data_i  input  T_DATA_WIDTH  input beat payload
- s_qos_i  input  T_QOS_WIDTH  input QoS tag
- s_id_i  input  T_ID_WIDTH  destination index, sampled on first beat of packet only
- s_last_i  input  1  last beat of packet
- s_valid_i  input  1  input beat valid
- s_ready_o  output  1  input beat accepted when s_valid_i & s_ready_o
- m_data_o  output  STREAM_COUNT*T_DATA_WIDTH  per-output payload, output k at slice k
- m_qos_o  output  STREAM_COUNT*T_QOS_WIDTH  per-output QoS tag
- m_last_o  output  STREAM_COUNT  per-output last flag
- m_valid_o  output  STREAM_COUNT  per-output valid
- m_ready_i  input  STREAM_COUNT  per-output ready
- drop_cnt_o  output  8  count of dropped packets, saturating

Behaviour:
Reset (async, nrst low):
- state=IDLE, sel_r=0.
- All m_valid_o=0; m_data_o, m_qos_o and m_last_o=0.
- drop_cnt_o=0.
- Applies immediately mid-packet; the partial packet is abandoned.
- After reset the next accepted beat is treated as a first beat.

Per-output slot k (register full_k drives m_valid_o[k]):
- free_k = ~full_k | m_ready_i[k].
- push_k = input handshake routed to k. On push_k, load data/qos/last and set full_k=1.
- Pop (full_k & m_ready_i[k]) without push_k: full_k=0.
- Pop and push in the same cycle: stays full, new beat loaded. Back-to-back throughput is 1 beat/cycle.
- While m_valid_o[k]=1 & m_ready_i[k]=0, the outputs hold stable.

Latency:
- Beat accepted in cycle N appears on m_*_o[k] with m_valid_o[k]=1 in cycle N+1.

FSM states: IDLE, FWD, DROP.
- IDLE, destination tgt=s_id_i:
  - If tgt<STREAM_COUNT: s_ready_o=free_tgt. On handshake, sel_r<=tgt; next state is FWD if ~s_last_i, else stays IDLE.
  - If tgt>=STREAM_COUNT: s_ready_o=1 and the beat is discarded. On handshake, drop_cnt_o increments (saturates at 255); next state is DROP if ~s_last_i, else stays IDLE.
- FWD:
  - s_ready_o=free_sel_r; s_id_i is ignored.
  - A handshake with s_last_i returns to IDLE.
- DROP:
  - s_ready_o=1; beats are discarded without counting.
  - A handshake with s_last_i returns to IDLE.

Combinational paths and constraints:
- s_ready_o depends combinationally on m_ready_i and s_id_i; there is no combinational path from s_valid_i to s_ready_o.
- Only one output is pushed per cycle.
- Other outputs drain independently while one is stalled; there is no head-of-line blocking from idle outputs.

Test Plan:
- Single-beat routing: after reset, m_ready_i=2'b11; drive id=1, data=8'hA5, qos=3, last=1. Required: s_ready_o=1; next cycle m_valid_o=2'b10, m_data_o[1]=8'hA5, m_qos_o[1]=3, m_last_o[1]=1; m_valid_o[0] stays 0.
- Route lock: 4-beat packet with id=0 on beat 0, then s_id_i toggled to 1 on beats 1-3, data 1..4. Required: all 4 beats appear on output 0 in order, last only on beat 4; output 1 is never valid.
- Backpressure: m_ready_i[0]=0 while streaming to output 0. Required: first beat registered, then s_ready_o=0; m_data_o[0] holds its value. Raise m_ready_i[0]=1 with continuous s_valid_i. Required: 1 beat/cycle with no bubbles and no loss.
- Independent outputs: output 0 stalled and full; send a packet to id=1. Required: it is accepted and delivered on output 1 with 1-cycle latency.
- Drop: STREAM_COUNT=3, T_ID_WIDTH=2, 3-beat packet with id=3. Required: s_ready_o=1 for every beat, no m_valid_o asserted, drop_cnt_o goes 0->1. Then send 300 single-beat id=3 packets. Required: drop_cnt_o=255 (saturated).
- Reset mid-packet: assert nrst=0 after beat 2 of a 5-beat FWD packet to output 1. Required: m_valid_o=0 immediately, drop_cnt_o=0. After release, a beat with id=0 routes to output 0 (state IDLE, lock cleared).

Source files
------------

// File: rtl/stream_demux.sv
// stream_demux: packet-level valid/ready stream demultiplexer.
// Routes each input packet to one of STREAM_COUNT outputs, chosen by s_id_i
// on the packet's first beat. The route is held until the last beat. Packets
// with an out-of-range id are consumed, discarded and counted.
// Each output has a single-entry register slice: 1-cycle latency at full rate.
//
// Ports:
//   clk, nrst        clock (rising edge), asynchronous active-low reset
//   s_data_i/s_qos_i input beat payload and QoS tag
//   s_id_i           destination index, used on the first beat only
//   s_last_i         last beat of packet
//   s_valid_i        input beat valid
//   s_ready_o        input beat accepted when s_valid_i & s_ready_o
//   m_data_o/m_qos_o per-output payload/QoS, output k at slice k
//   m_last_o         per-output last flag
//   m_valid_o        per-output valid
//   m_ready_i        per-output ready
//   drop_cnt_o       saturating count of dropped packets
module stream_demux #(
  parameter int STREAM_COUNT = 2,
  parameter int T_DATA_WIDTH = 8,
  parameter int T_QOS_WIDTH  = 4,
  parameter int T_ID_WIDTH   = 1
) (
  input  logic                                 clk,
  input  logic                                 nrst,
  input  logic [T_DATA_WIDTH-1:0]              s_data_i,
  input  logic [T_QOS_WIDTH-1:0]               s_qos_i,
  input  logic [T_ID_WIDTH-1:0]                s_id_i,
  input  logic                                 s_last_i,
  input  logic                                 s_valid_i,
  output logic                                 s_ready_o,
  output logic [STREAM_COUNT*T_DATA_WIDTH-1:0] m_data_o,
  output logic [STREAM_COUNT*T_QOS_WIDTH-1:0]  m_qos_o,
  output logic [STREAM_COUNT-1:0]              m_last_o,
  output logic [STREAM_COUNT-1:0]              m_valid_o,
  input  logic [STREAM_COUNT-1:0]              m_ready_i,
  output logic [7:0]                           drop_cnt_o
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

  // One extra bit so the range check cannot wrap when STREAM_COUNT == 2**T_ID_WIDTH.
  localparam logic [T_ID_WIDTH:0] COUNT_EXT = (T_ID_WIDTH+1)'(STREAM_COUNT);

  state_t                                   state;
  logic [T_ID_WIDTH-1:0]                    sel_r;
  logic [STREAM_COUNT-1:0]                  full;
  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] data_r;
  logic [STREAM_COUNT-1:0][T_QOS_WIDTH-1:0]  qos_r;
  logic [STREAM_COUNT-1:0]                  last_r;

  logic                    id_ok;
  logic                    dropping;
  logic [T_ID_WIDTH-1:0]   dest;
  logic [STREAM_COUNT-1:0] dest_oh;
  logic [STREAM_COUNT-1:0] free_v;
  logic [STREAM_COUNT-1:0] push;
  logic                    hs;

  always_comb begin
    id_ok    = ({1'b0, s_id_i} < COUNT_EXT);
    dropping = (state == DROP) || ((state == IDLE) && !id_ok);
    dest     = (state == FWD) ? sel_r : s_id_i;
    for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
      dest_oh[k] = (dest == T_ID_WIDTH'(k));
    end
    free_v    = ~full | m_ready_i;
    // Ready never looks at s_valid_i; discarded beats are always accepted.
    s_ready_o = dropping ? 1'b1 : |(free_v & dest_oh);
    hs        = s_valid_i & s_ready_o;
    push      = (hs && !dropping) ? dest_oh : '0;
  end

  // Routing/drop control.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      sel_r      <= '0;
      drop_cnt_o <= '0;
    end else if (hs) begin
      case (state)
        IDLE: begin
          if (id_ok) begin
            sel_r <= s_id_i;
            state <= s_last_i ? IDLE : FWD;
          end else begin
            if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 8'd1;
            state <= s_last_i ? IDLE : DROP;
          end
        end
        FWD:     if (s_last_i) state <= IDLE;
        DROP:    if (s_last_i) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Per-output register slices; a push overrides a simultaneous pop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      full   <= '0;
      data_r <= '0;
      qos_r  <= '0;
      last_r <= '0;
    end else begin
      for (int unsigned k = 0; k < STREAM_COUNT; k++) begin
        if (push[k]) begin
          full[k]   <= 1'b1;
          data_r[k] <= s_data_i;
          qos_r[k]  <= s_qos_i;
          last_r[k] <= s_last_i;
        end else if (m_ready_i[k]) begin
          full[k] <= 1'b0;
        end
      end
    end
  end

  assign m_valid_o = full;
  assign m_data_o  = data_r;
  assign m_qos_o   = qos_r;
  assign m_last_o  = last_r;

endmodule

// File: tb/tb_stream_demux.sv
module tb_stream_demux;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance (2 outputs, 1-bit id)
  logic [7:0]  s_data;
  logic [3:0]  s_qos;
  logic [0:0]  s_id;
  logic        s_last, s_valid, s_ready;
  logic [15:0] m_data;
  logic [7:0]  m_qos;
  logic [1:0]  m_last, m_valid, m_ready;
  logic [7:0]  drop_cnt;

  stream_demux dut (
    .clk(clk), .nrst(nrst),
    .s_data_i(s_data), .s_qos_i(s_qos), .s_id_i(s_id), .s_last_i(s_last),
    .s_valid_i(s_valid), .s_ready_o(s_ready),
    .m_data_o(m_data), .m_qos_o(m_qos), .m_last_o(m_last),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .drop_cnt_o(drop_cnt)
  );

  // 3-output instance with 2-bit id, so id=3 is out of range
  logic [7:0]  s3_data;
  logic [3:0]  s3_qos;
  logic [1:0]  s3_id;
  logic        s3_last, s3_valid, s3_ready;
  logic [23:0] m3_data;
  logic [11:0] m3_qos;
  logic [2:0]  m3_last, m3_valid, m3_ready;
  logic [7:0]  drop3_cnt;

  stream_demux #(.STREAM_COUNT(3), .T_ID_WIDTH(2)) dut3 (
    .clk(clk), .nrst(nrst),
    .s_data_i(s3_data), .s_qos_i(s3_qos), .s_id_i(s3_id), .s_last_i(s3_last),
    .s_valid_i(s3_valid), .s_ready_o(s3_ready),
    .m_data_o(m3_data), .m_qos_o(m3_qos), .m_last_o(m3_last),
    .m_valid_o(m3_valid), .m_ready_i(m3_ready), .drop_cnt_o(drop3_cnt)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [0:0]  id;
    logic [7:0]  data;
    logic [3:0]  qos;
    logic        last;
    logic        valid;
    logic [1:0]  mr;
    logic        exp_ready;
    logic [1:0]  exp_valid;
    logic [15:0] exp_data;
    logic [1:0]  exp_last;
    logic [7:0]  exp_qos;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [0:0] id, input logic [7:0] data, input logic [3:0] qos,
                              input logic last, input logic valid, input logic [1:0] mr,
                              input logic er, input logic [1:0] ev, input logic [15:0] ed,
                              input logic [1:0] el, input logic [7:0] eq);
    vec_t v;
    v.id = id; v.data = data; v.qos = qos; v.last = last; v.valid = valid; v.mr = mr;
    v.exp_ready = er; v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_qos = eq;
    return v;
  endfunction

  initial begin
    //            id  data   qos  last vld mr     rdy  valid  data      last   qos
    // single-beat routing to output 1, then drain
    vecs[0]  = mk(1, 8'hA5, 3, 1, 1, 2'b11, 1, 2'b10, 16'hA500, 2'b10, 8'h30);
    vecs[1]  = mk(0, 8'h00, 0, 0, 0, 2'b11, 1, 2'b00, 16'hA500, 2'b10, 8'h30);
    // route lock: id toggles to 1 after first beat, stays on output 0
    vecs[2]  = mk(0, 8'h01, 0, 0, 1, 2'b11, 1, 2'b01, 16'hA501, 2'b10, 8'h30);
    vecs[3]  = mk(1, 8'h02, 0, 0, 1, 2'b11, 1, 2'b01, 16'hA502, 2'b10, 8'h30);
    vecs[4]  = mk(1, 8'h03, 0, 0, 1, 2'b11, 1, 2'b01, 16'hA503, 2'b10, 8'h30);
    vecs[5]  = mk(1, 8'h04, 0, 1, 1, 2'b11, 1, 2'b01, 16'hA504, 2'b11, 8'h30);
    vecs[6]  = mk(0, 8'h00, 0, 0, 0, 2'b11, 1, 2'b00, 16'hA504, 2'b11, 8'h30);
    // backpressure on output 0, then full-rate drain
    vecs[7]  = mk(0, 8'h10, 0, 0, 1, 2'b10, 1, 2'b01, 16'hA510, 2'b10, 8'h30);
    vecs[8]  = mk(1, 8'h11, 0, 0, 1, 2'b10, 0, 2'b01, 16'hA510, 2'b10, 8'h30);
    vecs[9]  = mk(1, 8'h11, 0, 0, 1, 2'b10, 0, 2'b01, 16'hA510, 2'b10, 8'h30);
    vecs[10] = mk(1, 8'h11, 0, 0, 1, 2'b11, 1, 2'b01, 16'hA511, 2'b10, 8'h30);
    vecs[11] = mk(1, 8'h12, 0, 0, 1, 2'b11, 1, 2'b01, 16'hA512, 2'b10, 8'h30);
    vecs[12] = mk(1, 8'h13, 0, 1, 1, 2'b11, 1, 2'b01, 16'hA513, 2'b11, 8'h30);
    vecs[13] = mk(0, 8'h00, 0, 0, 0, 2'b11, 1, 2'b00, 16'hA513, 2'b11, 8'h30);
    // independent outputs: output 0 stalled full, packet to output 1 passes
    vecs[14] = mk(0, 8'h20, 0, 1, 1, 2'b10, 1, 2'b01, 16'hA520, 2'b11, 8'h30);
    vecs[15] = mk(1, 8'h30, 5, 1, 1, 2'b10, 1, 2'b11, 16'h3020, 2'b11, 8'h50);
    vecs[16] = mk(0, 8'h00, 0, 0, 0, 2'b10, 0, 2'b01, 16'h3020, 2'b11, 8'h50);
    vecs[17] = mk(1, 8'h00, 0, 0, 0, 2'b01, 1, 2'b00, 16'h3020, 2'b11, 8'h50);

    s_data = '0; s_qos = '0; s_id = '0; s_last = 0; s_valid = 0; m_ready = 2'b11;
    s3_data = '0; s3_qos = '0; s3_id = '0; s3_last = 0; s3_valid = 0; m3_ready = 3'b111;

    repeat (3) @(posedge clk);
    #1;
    chk("reset m_valid", 32'(m_valid), 0);
    chk("reset m_data", 32'(m_data), 0);
    chk("reset m_last", 32'(m_last), 0);
    chk("reset drop_cnt", 32'(drop_cnt), 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++) begin
      s_id = vecs[i].id; s_data = vecs[i].data; s_qos = vecs[i].qos;
      s_last = vecs[i].last; s_valid = vecs[i].valid; m_ready = vecs[i].mr;
      #1;
      chk($sformatf("vec%0d s_ready", i), 32'(s_ready), 32'(vecs[i].exp_ready));
      @(posedge clk); #1;
      chk($sformatf("vec%0d m_valid", i), 32'(m_valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d m_data", i), 32'(m_data), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d m_last", i), 32'(m_last), 32'(vecs[i].exp_last));
      chk($sformatf("vec%0d m_qos", i), 32'(m_qos), 32'(vecs[i].exp_qos));
    end
    s_valid = 0; m_ready = 2'b11;
    chk("no drops on in-range ids", 32'(drop_cnt), 0);

    // Drop: 3-beat packet with id=3; later beats carry in-range ids but must be discarded
    chk("drop3 initial", 32'(drop3_cnt), 0);
    for (int b = 0; b < 3; b++) begin
      s3_id = (b == 0) ? 2'd3 : 2'(b - 1);
      s3_data = 8'(8'hA0 + b); s3_last = (b == 2); s3_valid = 1;
      #1;
      chk($sformatf("drop beat%0d s_ready", b), 32'(s3_ready), 1);
      @(posedge clk); #1;
      chk($sformatf("drop beat%0d m_valid", b), 32'(m3_valid), 0);
      chk($sformatf("drop beat%0d drop_cnt", b), 32'(drop3_cnt), 1);
    end
    // Back to IDLE: id=2 is in range and routes to output 2
    s3_id = 2'd2; s3_data = 8'h77; s3_last = 1;
    #1;
    chk("dut3 id2 s_ready", 32'(s3_ready), 1);
    @(posedge clk); #1;
    chk("dut3 id2 m_valid", 32'(m3_valid), 32'h4);
    chk("dut3 id2 m_data", 32'(m3_data[23:16]), 32'h77);
    chk("dut3 id2 drop_cnt", 32'(drop3_cnt), 1);
    // Saturation
    s3_id = 2'd3;
    for (int p = 0; p < 300; p++) begin
      #1;
      chk($sformatf("sat pkt%0d s_ready", p), 32'(s3_ready), 1);
      @(posedge clk); #1;
    end
    s3_valid = 0;
    chk("drop_cnt saturated", 32'(drop3_cnt), 255);
    chk("no output during drops", 32'(m3_valid), 0);

    // Reset mid-packet: 5-beat packet to output 1, reset after beat 2
    m_ready = 2'b11;
    for (int b = 0; b < 2; b++) begin
      s_id = (b == 0) ? 1'b1 : 1'b0;
      s_data = 8'(8'h41 + b); s_last = 0; s_valid = 1;
      @(posedge clk); #1;
    end
    chk("pre-reset m_valid", 32'(m_valid), 32'h2);
    chk("pre-reset m_data1", 32'(m_data[15:8]), 32'h42);
    s_valid = 0;
    nrst = 0;
    #1;
    chk("async reset m_valid", 32'(m_valid), 0);
    chk("async reset m_data", 32'(m_data), 0);
    chk("async reset drop_cnt", 32'(drop_cnt), 0);
    chk("async reset dut3 drop_cnt", 32'(drop3_cnt), 0);
    @(posedge clk); #1;
    nrst = 1;
    @(posedge clk); #1;
    s_id = 1'b0; s_data = 8'h55; s_last = 1; s_valid = 1;
    #1;
    chk("post-reset s_ready", 32'(s_ready), 1);
    @(posedge clk); #1;
    s_valid = 0;
    chk("post-reset m_valid", 32'(m_valid), 32'h1);
    chk("post-reset m_data0", 32'(m_data[7:0]), 32'h55);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
